feat_window_buf: RTL and testbench
==================================

# feat_window_buf

Collects the per-coefficient stream produced by the CMVN stage (one normalized 1.7.24 word per valid, tagged with coefficient index 0..19) into whole frames. It keeps a ring of the most recent frames and, each time a frame completes with a full context window available, streams the window to the downstream KWS network engine. The stream is ordered oldest frame first, coefficient 0..19 within each frame, over a valid/ready handshake. It also tracks sequencing errors and overruns as sticky flags.

## Interface
- NUM_FEAT, 20, coefficients per frame
- WIN_FRAMES, 8, frames per output window
- DATA_W, 32, word width (1.7.24 signed, passed through unmodified)
- DEPTH (local), WIN_FRAMES+1, ring slots; the extra slot lets writes proceed while a window is read
- FRM_W (local), $clog2(WIN_FRAMES); SLOT_W (local), $clog2(DEPTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of pointers, counts, FSM and flags; memory contents are not cleared
- in_valid  in  1  sample strobe, from CMVN output_valid
- in_data  in  DATA_W  normalized coefficient
- in_addr  in  5  coefficient index
- out_valid  out  1  window word available
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  window word
- out_frame  out  FRM_W  frame index within window; 0 = oldest
- out_feat  out  5  coefficient index
- out_last  out  1  final word of window
- win_ready  out  1  at least WIN_FRAMES frames held
- err_seq  out  1  sticky: out-of-order in_addr seen
- overrun  out  1  sticky: samples dropped

## Operation
- Write side: `exp_addr` counter, `wr_slot` pointer, `avail` count (saturates at WIN_FRAMES), `pend` flag.
- in_valid with in_addr == exp_addr: write mem[wr_slot][in_addr], then exp_addr++.
- Accepting index NUM_FEAT-1 is a commit:
  - exp_addr ← 0
  - wr_slot ← (wr_slot+1) mod DEPTH
  - avail ← min(avail+1, WIN_FRAMES)
  - newest ← old wr_slot
- in_valid with in_addr != exp_addr:
  - err_seq ← 1 and the partial frame is discarded.
  - If in_addr == 0, the sample is accepted as the start of a new frame (exp_addr ← 1).
  - Otherwise the sample is dropped (exp_addr ← 0).
- Start condition: a commit with post-commit avail == WIN_FRAMES.
  - IDLE: FSM → STREAM with base slot = (newest − WIN_FRAMES + 1) mod DEPTH.
  - STREAM: pend ← 1 and pend_newest is recorded.
- While in STREAM with pend == 1, every in_valid is dropped: overrun ← 1 and exp_addr ← 0. The next frame would overwrite the slot being read.
- FSM states:
  - IDLE: out_valid = 0.
  - STREAM: out_valid = 1. out_data = mem[(base+out_frame) mod DEPTH][out_feat]. On out_valid && out_ready, advance out_feat 0..NUM_FEAT−1, then out_frame. out_last = (out_frame == WIN_FRAMES−1 && out_feat == NUM_FEAT−1).
  - Transfer with out_last: if pend, restart STREAM at pend_newest's window and clear pend; else go to IDLE. out_frame and out_feat return to 0.
- win_ready = (avail == WIN_FRAMES).
- Simultaneous events: a commit and a final-word transfer in the same cycle → the new window starts immediately (it is never queued).
- clear has priority over all in-cycle events.

## Timing
- Reset (async) and clear (sync) both force: out_valid = 0, out_data = 0, out_frame = 0, out_feat = 0, out_last = 0, win_ready = 0, err_seq = 0, overrun = 0. Also state IDLE, avail = 0, wr_slot = 0, exp_addr = 0, pend = 0.
- Commit sampled at edge k → out_valid = 1 after edge k+1. The first word is the oldest frame, coefficient 0.
- One word per cycle while out_ready = 1: a window takes WIN_FRAMES×NUM_FEAT = 160 cycles minimum.
- While out_valid && !out_ready, out_data, out_frame, out_feat and out_last hold stable.
- Sticky flags set at the edge that samples the offending input.
- Reset mid-stream abandons the window with no partial completion; out_valid falls immediately (asynchronous).

## Test plan
- Reset: assert rst_n = 0 mid-stream → all outputs 0 asynchronously; after release, 7 frames produce no out_valid and win_ready = 0.
- Fill: 8 frames, data = frame×256+addr, out_ready = 1 → win_ready = 1. out_valid rises 2 edges after the addr-19 sample of frame 7. 160 words follow: the first is 0x0000, the last is 0x0713 with out_last = 1 and out_frame = 7, out_feat = 19. Then IDLE.
- Slide: a 9th frame (0x08xx) while idle → window frames 1..8; first word 0x0100, last 0x0813; slot wrap across DEPTH = 9 is correct.
- Backpressure: out_ready toggled 1-0-0-1 randomly → outputs stable while stalled; 160 words in order; no duplicates or losses.
- Sequence error: addrs 0..5, then 9, then 0..19 → err_seq = 1; addr 9 is dropped; the following frame is committed intact; the stray word never appears in any window.
- Overrun: out_ready = 0 after fill, then two more frames → the first sets pend. Samples of the second are dropped and overrun = 1. After releasing out_ready, a second window streams with last word 0x0813.

Source files
------------

// File: rtl/feat_window_buf.sv
// Frame assembler and sliding context-window streamer between CMVN and the KWS engine.
// A ring of WIN_FRAMES+1 frame slots lets the next frame land while a window is being read out.
module feat_window_buf #(
  parameter int NUM_FEAT   = 20,
  parameter int WIN_FRAMES = 8,
  parameter int DATA_W     = 32,
  localparam int FRM_W     = $clog2(WIN_FRAMES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FRM_W-1:0]  out_frame,
  output logic [4:0]        out_feat,
  output logic              out_last,
  output logic              win_ready,
  output logic              err_seq,
  output logic              overrun
);

  localparam int DEPTH  = WIN_FRAMES + 1;
  localparam int SLOT_W = $clog2(DEPTH);
  localparam int AV_W   = FRM_W + 1;
  localparam int IDX_W  = $clog2(DEPTH * NUM_FEAT);
  localparam logic [4:0] FEAT_MAX = 5'(NUM_FEAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  function automatic logic [SLOT_W-1:0] wrap(input logic [SLOT_W:0] s);
    logic [SLOT_W:0] d;
    d = s - (SLOT_W+1)'(DEPTH);
    return (s >= (SLOT_W+1)'(DEPTH)) ? d[SLOT_W-1:0] : s[SLOT_W-1:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH*NUM_FEAT];
  logic [DATA_W-1:0] rd_q;

  state_t            state_reg, state_next;
  logic [4:0]        exp_addr_reg, exp_addr_next;
  logic [SLOT_W-1:0] wr_slot_reg, base_reg, base_next, pend_base_reg, pend_base_next;
  logic [AV_W-1:0]   avail_reg, avail_inc;
  logic              pend_reg, pend_next, valid_reg, valid_next, err_reg, ovr_reg;
  logic [FRM_W-1:0]  frame_reg, frame_next;
  logic [4:0]        feat_reg, feat_next;

  logic              wr_en, commit, err_hit, ovr_hit, start, xfer, last, rd_en;
  logic [SLOT_W-1:0] start_base, rd_slot;
  logic [4:0]        rd_feat;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  // While a window is pending behind the current one, the slot the next frame would
  // use is still being read, so input is dropped wholesale.
  always_comb begin
    wr_en         = 1'b0;
    commit        = 1'b0;
    err_hit       = 1'b0;
    ovr_hit       = 1'b0;
    exp_addr_next = exp_addr_reg;
    if (in_valid) begin
      if (pend_reg) begin
        ovr_hit       = 1'b1;
        exp_addr_next = 5'd0;
      end else if (in_addr == exp_addr_reg) begin
        wr_en = 1'b1;
        if (in_addr == FEAT_MAX) begin
          commit        = 1'b1;
          exp_addr_next = 5'd0;
        end else begin
          exp_addr_next = exp_addr_reg + 5'd1;
        end
      end else begin
        err_hit = 1'b1;
        if (in_addr == 5'd0) begin
          wr_en         = 1'b1;
          exp_addr_next = 5'd1;
        end else begin
          exp_addr_next = 5'd0;
        end
      end
    end
  end

  assign avail_inc  = (avail_reg == AV_W'(WIN_FRAMES)) ? avail_reg : avail_reg + 1'b1;
  assign start      = commit && (avail_inc == AV_W'(WIN_FRAMES));
  assign start_base = wrap({1'b0, wr_slot_reg} + (SLOT_W+1)'(DEPTH - WIN_FRAMES + 1));
  assign xfer       = valid_reg && out_ready;
  assign last       = (frame_reg == FRM_W'(WIN_FRAMES - 1)) && (feat_reg == FEAT_MAX);

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    frame_next     = frame_reg;
    feat_next      = feat_reg;
    valid_next     = valid_reg;
    pend_next      = pend_reg;
    pend_base_next = pend_base_reg;
    rd_en          = 1'b0;
    rd_slot        = base_reg;
    rd_feat        = 5'd0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          base_next  = start_base;
          frame_next = '0;
          feat_next  = 5'd0;
        end
      end
      LOAD: begin
        rd_en      = 1'b1;
        valid_next = 1'b1;
        state_next = STREAM;
        if (start) begin
          pend_next      = 1'b1;
          pend_base_next = start_base;
        end
      end
      STREAM: begin
        if (xfer && last) begin
          // Back-to-back windows: fetch word 0 of the next window without a bubble.
          frame_next = '0;
          feat_next  = 5'd0;
          if (pend_reg) begin
            base_next = pend_base_reg;
            pend_next = 1'b0;
            rd_en     = 1'b1;
            rd_slot   = pend_base_reg;
          end else if (start) begin
            base_next = start_base;
            rd_en     = 1'b1;
            rd_slot   = start_base;
          end else begin
            state_next = IDLE;
            valid_next = 1'b0;
          end
        end else begin
          if (start) begin
            pend_next      = 1'b1;
            pend_base_next = start_base;
          end
          if (xfer) begin
            if (feat_reg == FEAT_MAX) begin
              feat_next  = 5'd0;
              frame_next = frame_reg + 1'b1;
            end else begin
              feat_next = feat_reg + 1'b1;
            end
            rd_en   = 1'b1;
            rd_slot = wrap({1'b0, base_reg} + (SLOT_W+1)'(frame_next));
            rd_feat = feat_next;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_idx = IDX_W'(wr_slot_reg) * IDX_W'(NUM_FEAT) + IDX_W'(in_addr);
  assign rd_idx = IDX_W'(rd_slot) * IDX_W'(NUM_FEAT) + IDX_W'(rd_feat);

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_idx] <= in_data;
    if (rd_en) rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      exp_addr_reg  <= 5'd0;
      wr_slot_reg   <= '0;
      avail_reg     <= '0;
      pend_reg      <= 1'b0;
      pend_base_reg <= '0;
      base_reg      <= '0;
      frame_reg     <= '0;
      feat_reg      <= 5'd0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
    end else if (clear) begin
      state_reg     <= IDLE;
      exp_addr_reg  <= 5'd0;
      wr_slot_reg   <= '0;
      avail_reg     <= '0;
      pend_reg      <= 1'b0;
      pend_base_reg <= '0;
      base_reg      <= '0;
      frame_reg     <= '0;
      feat_reg      <= 5'd0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      exp_addr_reg  <= exp_addr_next;
      if (commit) begin
        wr_slot_reg <= wrap({1'b0, wr_slot_reg} + 1'b1);
        avail_reg   <= avail_inc;
      end
      pend_reg      <= pend_next;
      pend_base_reg <= pend_base_next;
      base_reg      <= base_next;
      frame_reg     <= frame_next;
      feat_reg      <= feat_next;
      valid_reg     <= valid_next;
      err_reg       <= err_reg | err_hit;
      ovr_reg       <= ovr_reg | ovr_hit;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = valid_reg ? rd_q : '0;
  assign out_frame = frame_reg;
  assign out_feat  = feat_reg;
  assign out_last  = valid_reg && last;
  assign win_ready = (avail_reg == AV_W'(WIN_FRAMES));
  assign err_seq   = err_reg;
  assign overrun   = ovr_reg;

endmodule

// File: tb/tb_feat_window_buf.sv
// Directed/random bench for feat_window_buf: a frame-history model predicts every
// streamed word, its position tags and the sticky flags.
module tb_feat_window_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_frame;
  logic [4:0]  out_feat;
  logic        out_last;
  logic        win_ready;
  logic        err_seq;
  logic        overrun;

  feat_window_buf dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_frame(out_frame), .out_feat(out_feat), .out_last(out_last),
    .win_ready(win_ready), .err_seq(err_seq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: committed frames as a flat word history (last 8 frames), the frame being
  // assembled, and the queue of words the DUT still owes downstream.
  logic [31:0] hist_w[$];
  logic [31:0] part [20];
  int          part_n = 0;
  logic [31:0] expq[$];
  int          rx_count = 0;
  logic        model_err = 1'b0;
  logic        model_ovr = 1'b0;
  logic [31:0] last_word = '0;
  logic [31:0] exp_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_flush();
    expq.delete();
    hist_w.delete();
    part_n    = 0;
    rx_count  = 0;
    model_err = 1'b0;
    model_ovr = 1'b0;
  endfunction

  function automatic void model_sample(input int a, input logic [31:0] d);
    if (expq.size() > 160) begin
      model_ovr = 1'b1;
      part_n    = 0;
      return;
    end
    if (a == part_n) begin
      part[a] = d;
      part_n++;
      if (part_n == 20) begin
        for (int i = 0; i < 20; i++) hist_w.push_back(part[i]);
        while (hist_w.size() > 160) void'(hist_w.pop_front());
        part_n = 0;
        if (hist_w.size() == 160)
          for (int i = 0; i < 160; i++) expq.push_back(hist_w[i]);
      end
    end else begin
      model_err = 1'b1;
      if (a == 0) begin
        part[0] = d;
        part_n  = 1;
      end else begin
        part_n = 0;
      end
    end
  endfunction

  task automatic send(input int a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = 5'(a);
    in_data  = d;
    @(posedge clk);
    model_sample(a, d);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int f, input bit directed);
    for (int a = 0; a < 20; a++)
      send(a, directed ? 32'(f * 256 + a) : $urandom);
  endtask

  task automatic wait_drain(input bit rand_bp);
    int cyc = 0;
    while (expq.size() != 0 && cyc < 5000) begin
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b1;
    chk("drain", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_window", 64'(out_valid), 64'd0);
  endtask

  // Output monitor: every handshake is matched against the model; stalled words must hold.
  logic        prev_stall = 1'b0;
  logic [40:0] prev_obs = '0;
  initial begin
    logic [40:0] obs, expcat;
    int pos;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        prev_stall = 1'b0;
      end else begin
        obs = {out_data, out_frame, out_feat, out_last};
        if (prev_stall) chk("stall_hold", 64'({out_valid, obs}), 64'({1'b1, prev_obs}));
        if (out_valid) begin
          chk("valid_expected", 64'(expq.size() != 0), 64'd1);
          if (out_ready && expq.size() != 0) begin
            pos    = rx_count % 160;
            expcat = {expq[0], 3'(pos / 20), 5'(pos % 20), pos == 159};
            chk("word", 64'(obs), 64'(expcat));
            if (out_last) last_word = out_data;
            void'(expq.pop_front());
            rx_count++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_obs   = obs;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({out_valid, out_data, out_frame, out_feat, out_last, win_ready, err_seq, overrun}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill: 8 directed frames, first window after the 8th commit
    for (int f = 0; f < 7; f++) send_frame(f, 1'b1);
    chk("win_ready_7", 64'(win_ready), 64'd0);
    send_frame(7, 1'b1);
    chk("lat_edge_k", 64'(out_valid), 64'd0);
    chk("win_ready_8", 64'(win_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("lat_edge_k1", 64'({out_valid, out_data, out_frame, out_feat}), 64'({1'b1, 32'h0, 3'd0, 5'd0}));
    wait_drain(1'b0);
    chk("fill_last", 64'(last_word), 64'h0713);

    // Slide: 9th frame starts window of frames 1..8
    send_frame(8, 1'b1);
    wait_drain(1'b0);
    chk("slide_last", 64'(last_word), 64'h0813);

    // Backpressure with random data; these frames wrap the ring
    for (int k = 0; k < 3; k++) begin
      send_frame(0, 1'b0);
      wait_drain(1'b1);
    end

    // Sequence error: 0..5, stray 9, then a clean frame
    chk("err_seq_clear", 64'(err_seq), 64'd0);
    for (int a = 0; a < 6; a++) send(a, $urandom);
    send(9, 32'hDEAD_BEEF);
    chk("err_seq_set", 64'(err_seq), 64'(model_err));
    send_frame(0, 1'b0);
    wait_drain(1'b1);

    // Overrun: stall, one frame pends, the next is dropped
    out_ready = 1'b0;
    send_frame(0, 1'b0);
    send_frame(0, 1'b0);
    exp_last = hist_w[159];
    chk("overrun_clear", 64'(overrun), 64'd0);
    send_frame(0, 1'b0);
    chk("overrun_set", 64'(overrun), 64'(model_ovr));
    chk("overrun_queue", 64'(expq.size()), 64'd320);
    wait_drain(1'b0);
    chk("pend_window_last", 64'(last_word), 64'(exp_last));

    // Asynchronous reset mid-stream
    send_frame(0, 1'b0);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'({out_valid, out_data, out_frame, out_feat, out_last, win_ready, err_seq, overrun}), 64'd0);
    model_flush();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 7; f++) send_frame(f, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_7", 64'({out_valid, win_ready}), 64'd0);

    // Synchronous clear mid-stream, with a sticky error pending
    send_frame(7, 1'b0);
    chk("win_ready_again", 64'(win_ready), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    send(3, $urandom);
    chk("err_before_clear", 64'(err_seq), 64'(model_err));
    clear = 1'b1;
    @(posedge clk);
    model_flush();
    #1 clear = 1'b0;
    chk("clear_outs", 64'({out_valid, out_data, out_frame, out_feat, out_last, win_ready, err_seq, overrun}), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("clear_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
